// File: rtl/sseg_scan_decoder.sv
// Passive monitor for a multiplexed four-digit active-low seven-segment bus:
// waits for each scanned digit to settle, decodes it to BCD and assembles HH:MM frames.
module sseg_scan_decoder #(
    parameter int unsigned SETTLE  = 16,
    parameter int unsigned TIMEOUT = 200000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [6:0]  sseg,
    input  logic [3:0]  dgt,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        err,
    output logic        scan_lost
);
    localparam int unsigned SCW = $clog2(SETTLE + 1);
    localparam int unsigned TOW = $clog2(TIMEOUT + 1);
    localparam logic [SCW-1:0] SCNT_LAST = SCW'(SETTLE - 1);
    localparam logic [SCW-1:0] SCNT_MAX  = SCW'(SETTLE);
    localparam logic [TOW-1:0] TCNT_MAX  = TOW'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

    logic [6:0]     sseg_m_q, sseg_m_d, sseg_s_q, sseg_s_d, sseg_p_q, sseg_p_d;
    logic [3:0]     dgt_m_q, dgt_m_d, dgt_s_q, dgt_s_d, dgt_p_q, dgt_p_d;
    state_t         state_q, state_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic [TOW-1:0] tcnt_q, tcnt_d;
    logic [2:0]     mask_q, mask_d;
    logic           ferr_q, ferr_d;
    logic [11:0]    shadow_q, shadow_d;
    logic [15:0]    digits_q, digits_d;
    logic           fv_q, fv_d;
    logic           err_q, err_d;
    logic           lost_q, lost_d;

    logic [3:0] sel, sel_prev;
    logic [1:0] idx;
    logic [6:0] seg_on;
    logic [3:0] seg_val;
    logic       seg_ok, multi, multi_prev, one_hot;
    logic       dgt_changed, bus_changed, sample;

    // Decode of the synchronized bus: selected digit index and segment value.
    always_comb begin
        sel         = ~dgt_s_q;
        sel_prev    = ~dgt_p_q;
        multi       = (sel & (sel - 4'd1)) != 4'd0;
        multi_prev  = (sel_prev & (sel_prev - 4'd1)) != 4'd0;
        one_hot     = (sel != 4'd0) && !multi;
        dgt_changed = dgt_s_q != dgt_p_q;
        bus_changed = dgt_changed || (sseg_s_q != sseg_p_q);

        case (sel)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase

        seg_on  = ~sseg_s_q;
        seg_ok  = 1'b1;
        seg_val = 4'd0;
        case (seg_on)
            7'h00:   seg_val = 4'd0;
            7'h3F:   seg_val = 4'd0;
            7'h06:   seg_val = 4'd1;
            7'h5B:   seg_val = 4'd2;
            7'h4F:   seg_val = 4'd3;
            7'h66:   seg_val = 4'd4;
            7'h6D:   seg_val = 4'd5;
            7'h7D:   seg_val = 4'd6;
            7'h07:   seg_val = 4'd7;
            7'h7F:   seg_val = 4'd8;
            7'h6F:   seg_val = 4'd9;
            default: seg_ok  = 1'b0;
        endcase
    end

    always_comb begin
        sseg_m_d = sseg;
        sseg_s_d = sseg_m_q;
        sseg_p_d = sseg_s_q;
        dgt_m_d  = dgt;
        dgt_s_d  = dgt_m_q;
        dgt_p_d  = dgt_s_q;
        state_d  = state_q;
        scnt_d   = scnt_q;
        tcnt_d   = tcnt_q;
        mask_d   = mask_q;
        ferr_d   = ferr_q;
        shadow_d = shadow_q;
        digits_d = digits_q;
        lost_d   = lost_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        sample   = 1'b0;

        // Multi-hot select overrides the scan FSM; err fires only on entry.
        if (multi) begin
            state_d = ST_IDLE;
            scnt_d  = '0;
            mask_d  = '0;
            err_d   = !multi_prev;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (one_hot) begin
                        state_d = ST_SETTLE;
                        scnt_d  = '0;
                    end
                end
                ST_SETTLE: begin
                    if (bus_changed) begin
                        scnt_d = '0;
                        if (!one_hot) state_d = ST_IDLE;
                    end else if (scnt_q == SCNT_LAST) begin
                        sample  = 1'b1;
                        state_d = ST_HOLD;
                    end else if (scnt_q != SCNT_MAX) begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (dgt_changed) begin
                        scnt_d  = '0;
                        state_d = one_hot ? ST_SETTLE : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Frame assembly: mask tracks the contiguous run of digits 0..2 collected.
        if (sample) begin
            err_d  = !seg_ok;
            tcnt_d = '0;
            case (idx)
                2'd0: begin
                    mask_d         = 3'b001;
                    ferr_d         = !seg_ok;
                    shadow_d[3:0]  = seg_val;
                end
                2'd1: begin
                    if (mask_q == 3'b001) begin
                        mask_d        = 3'b011;
                        ferr_d        = ferr_q || !seg_ok;
                        shadow_d[7:4] = seg_val;
                    end else begin
                        mask_d = '0;
                        ferr_d = 1'b0;
                    end
                end
                2'd2: begin
                    if (mask_q == 3'b011) begin
                        mask_d         = 3'b111;
                        ferr_d         = ferr_q || !seg_ok;
                        shadow_d[11:8] = seg_val;
                    end else begin
                        mask_d = '0;
                        ferr_d = 1'b0;
                    end
                end
                default: begin
                    mask_d = '0;
                    ferr_d = 1'b0;
                    if (mask_q == 3'b111 && !ferr_q && seg_ok) begin
                        digits_d = {seg_val, shadow_q};
                        fv_d     = 1'b1;
                    end
                end
            endcase
        end else if (tcnt_q != TCNT_MAX) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        // A sample in the expiry cycle suppresses scan_lost.
        if (fv_d) begin
            lost_d = 1'b0;
        end else if (!sample && tcnt_d == TCNT_MAX) begin
            lost_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sseg_m_q <= '1;
            sseg_s_q <= '1;
            sseg_p_q <= '1;
            dgt_m_q  <= '1;
            dgt_s_q  <= '1;
            dgt_p_q  <= '1;
            state_q  <= ST_IDLE;
            scnt_q   <= '0;
            tcnt_q   <= '0;
            mask_q   <= '0;
            ferr_q   <= 1'b0;
            shadow_q <= '0;
            digits_q <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            sseg_m_q <= sseg_m_d;
            sseg_s_q <= sseg_s_d;
            sseg_p_q <= sseg_p_d;
            dgt_m_q  <= dgt_m_d;
            dgt_s_q  <= dgt_s_d;
            dgt_p_q  <= dgt_p_d;
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            tcnt_q   <= tcnt_d;
            mask_q   <= mask_d;
            ferr_q   <= ferr_d;
            shadow_q <= shadow_d;
            digits_q <= digits_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            lost_q   <= lost_d;
        end
    end

    assign digits      = digits_q;
    assign frame_valid = fv_q;
    assign err         = err_q;
    assign scan_lost   = lost_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed display scenarios plus randomized scans,
// compared every cycle against a behavioural model of the bus protocol.
`timescale 1ns/1ps
module tb_sseg_scan_decoder;
    localparam int SET = 16;
    localparam int TMO = 500;

    typedef struct packed {
        logic [3:0] d;
        logic [6:0] s;
    } bus_t;
    localparam bus_t IDLE_BUS = {4'hF, 7'h7F};

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  sseg = 7'h7F;
    logic [3:0]  dgt = 4'hF;
    logic [15:0] digits;
    logic        frame_valid, err, scan_lost;

    sseg_scan_decoder #(.SETTLE(SET), .TIMEOUT(TMO)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sseg       (sseg),
        .dgt        (dgt),
        .digits     (digits),
        .frame_valid(frame_valid),
        .err        (err),
        .scan_lost  (scan_lost)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int fv_seen = 0;
    int err_seen = 0;

    // Glyphs as gfedcba, segment on = 1.
    logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // ---------------- behavioural model ----------------
    bus_t        hist[$];
    int          age, since, have;
    bit          sampled, bad;
    logic [3:0]  vals [4];
    logic [15:0] m_digits;
    bit          m_fv, m_err, m_lost;

    function automatic int lows(input logic [3:0] d);
        return $countones(~d);
    endfunction

    function automatic int decode(input logic [6:0] s);
        logic [6:0] on;
        on = ~s;
        if (on == 7'h00) return 0;
        for (int v = 0; v < 10; v++) if (glyph[v] == on) return v;
        return -1;
    endfunction

    // The model sees the raw bus two clocks late (synchronizer) and reasons in
    // terms of "how long has the bus been stable" and "which digit comes next".
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            repeat (4) hist.push_front(IDLE_BUS);
            age = 0; since = 0; have = 0; sampled = 0; bad = 0;
            m_digits = 16'h0000; m_fv = 0; m_err = 0; m_lost = 0;
        end else begin
            bus_t cur, prv;
            int   idx, v;
            bit   smp;
            hist.push_front(bus_t'({dgt, sseg}));
            cur = hist[2];
            prv = hist[3];
            void'(hist.pop_back());
            m_fv = 0; m_err = 0; smp = 0;
            if (cur != prv) age = 0; else if (age <= SET) age++;
            if (cur.d != prv.d) sampled = 0;
            if (lows(cur.d) >= 2) begin
                m_err = (lows(prv.d) < 2);
                have  = 0;
            end else if (lows(cur.d) == 1 && age == SET && !sampled) begin
                smp = 1; sampled = 1;
                idx = 0;
                for (int i = 0; i < 4; i++) if (!cur.d[i]) idx = i;
                v = decode(cur.s);
                m_err = (v < 0);
                if (idx == 0) begin
                    have = 1; bad = (v < 0); vals[0] = v[3:0];
                end else if (idx == have) begin
                    vals[idx] = v[3:0];
                    bad = bad || (v < 0);
                    have++;
                    if (have == 4) begin
                        if (!bad) begin
                            m_digits = {vals[3], vals[2], vals[1], vals[0]};
                            m_fv = 1;
                        end
                        have = 0;
                    end
                end else begin
                    have = 0;
                end
            end
            if (smp) begin
                since = 0;
                if (m_fv) m_lost = 0;
            end else begin
                if (since < TMO) since++;
                if (since == TMO) m_lost = 1;
            end
        end
    end

    always @(negedge clock) begin
        vectors++;
        if ({digits, frame_valid, err, scan_lost} !== {m_digits, m_fv, m_err, m_lost}) begin
            miscompares++;
            $display("FAIL outputs @%0t: digits/fv/err/lost got %h/%b/%b/%b want %h/%b/%b/%b",
                     $time, digits, frame_valid, err, scan_lost, m_digits, m_fv, m_err, m_lost);
        end
        if (frame_valid === 1'b1) fv_seen++;
        if (err === 1'b1) err_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
        dgt  = d;
        sseg = s;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic show(input int idx, input logic [6:0] on, input int n);
        logic [3:0] sel;
        sel = 4'hF;
        sel[idx] = 1'b0;
        hold(sel, ~on, n);
        hold(4'hF, 7'h7F, 4);
    endtask

    task automatic scan(input logic [15:0] bcd, input int n);
        for (int i = 0; i < 4; i++) show(i, glyph[bcd[4*i +: 4]], n);
    endtask

    initial begin
        int f0, e0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_fv", 32'(frame_valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_lost", 32'(scan_lost), 32'h0);
        reset_n = 1'b1;

        // Clean 12:34, two passes.
        f0 = fv_seen; e0 = err_seen;
        scan(16'h1234, 100);
        check("clean_fv_pass1", fv_seen - f0, 1);
        scan(16'h1234, 100);
        check("clean_fv_pass2", fv_seen - f0, 2);
        check("clean_digits", 32'(digits), 32'h1234);
        check("model_digits_1234", 32'(m_digits), 32'h1234);
        check("clean_err", err_seen - e0, 0);

        // 23:59 with a short glitch on digit 2.
        show(0, glyph[9], 100);
        show(1, glyph[5], 100);
        hold(4'b1011, ~glyph[3], 5);
        hold(4'b1011, ~glyph[8], SET - 2);
        show(2, glyph[3], 100);
        show(3, glyph[2], 100);
        check("glitch_digits", 32'(digits), 32'h2359);

        // Illegal pattern on digit 1, then a clean pass.
        f0 = fv_seen; e0 = err_seen;
        show(0, glyph[7], 100);
        show(1, 7'h49, 100);
        show(2, glyph[8], 100);
        show(3, glyph[1], 100);
        check("illegal_err", err_seen - e0, 1);
        check("illegal_fv", fv_seen - f0, 0);
        check("illegal_hold", 32'(digits), 32'h2359);
        scan(16'h1807, 100);
        check("after_illegal", 32'(digits), 32'h1807);

        // Out-of-order scan, then ascending.
        f0 = fv_seen; e0 = err_seen;
        show(0, glyph[1], 100);
        show(2, glyph[3], 100);
        show(1, glyph[2], 100);
        show(3, glyph[4], 100);
        check("order_fv", fv_seen - f0, 0);
        check("order_err", err_seen - e0, 0);
        scan(16'h4321, 100);
        check("order_restore_fv", fv_seen - f0, 1);
        check("order_restore_digits", 32'(digits), 32'h4321);

        // Timeout, then resume 08:15.
        hold(4'hF, 7'h7F, TMO + 10);
        check("timeout_lost", 32'(scan_lost), 32'h1);
        check("model_lost", 32'(m_lost), 32'h1);
        scan(16'h0815, 100);
        check("resume_lost", 32'(scan_lost), 32'h0);
        check("resume_digits", 32'(digits), 32'h0815);

        // Reset mid-frame.
        f0 = fv_seen;
        show(0, glyph[8], 100);
        show(1, glyph[7], 100);
        show(2, glyph[6], 100);
        reset_n = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        reset_n = 1'b1;
        f0 = fv_seen;
        show(3, glyph[5], 100);
        check("reset_mid_fv", fv_seen - f0, 0);
        check("reset_mid_digits", 32'(digits), 32'h0);
        e0 = err_seen;
        hold(4'b0011, 7'h7F, 10);
        hold(4'hF, 7'h7F, 5);
        check("multihot_err", err_seen - e0, 1);

        // Randomized scans: mixed dwell, gaps, glitches, illegal/blank glyphs,
        // order swaps, multi-hot blips and occasional long idles.
        for (int p = 0; p < 150; p++) begin
            int order [4];
            int a, b, t;
            order = '{0, 1, 2, 3};
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                t = order[a]; order[a] = order[b]; order[b] = t;
            end
            for (int i = 0; i < 4; i++) begin
                logic [3:0] sel;
                logic [6:0] on;
                int r;
                sel = 4'hF;
                sel[order[i]] = 1'b0;
                r = $urandom_range(0, 19);
                if (r == 0) on = 7'h00;
                else if (r == 1) on = 7'($urandom);
                else on = glyph[$urandom_range(0, 9)];
                if ($urandom_range(0, 9) == 0)
                    hold(sel, ~glyph[$urandom_range(0, 9)], $urandom_range(1, SET));
                hold(sel, ~on, $urandom_range(SET - 2, SET + 24));
                if ($urandom_range(0, 15) == 0) begin
                    sel[$urandom_range(0, 3)] = 1'b0;
                    hold(sel, ~on, $urandom_range(1, 5));
                end
                hold(4'hF, 7'h7F, $urandom_range(0, 3));
            end
            if ($urandom_range(0, 39) == 0) hold(4'hF, 7'h7F, TMO + $urandom_range(0, 20));
        end

        hold(4'hF, 7'h7F, 30);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

Passive receiver for the multiplexed four-digit seven-segment bus driven by the alarm clock display path. It samples the active-low segment and digit-select lines, waits for each scanned digit to settle, decodes the segment pattern back to BCD, and assembles complete HH:MM frames. Used as a bench/board-level monitor and as a readback for the displayed time.

## Interface
- SETTLE, 16, clocks that dgt and sseg must be stable before a digit is sampled (≥2)
- TIMEOUT, 200000, clocks without an accepted sample before scan_lost asserts
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sseg  in  7  segment lines, active-low; bit0=a … bit6=g
- dgt  in  4  digit enables, active-low one-hot; dgt[0]=minute ones … dgt[3]=hour tens
- digits  out  16  last valid frame, BCD; [15:12]=hour tens, [3:0]=minute ones
- frame_valid  out  1  one-cycle pulse when digits updates
- err  out  1  one-cycle pulse on illegal segment pattern or multi-hot dgt
- scan_lost  out  1  level; no accepted sample for TIMEOUT clocks

## Operation
- Inputs pass a 2-FF synchronizer; all logic below uses synchronized copies.
- Segment decode (after inversion, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. 00 decodes to blank (value 0, not an error). Any other pattern is illegal.
- FSM states:
  - IDLE: dgt all-high (no digit selected). Go to SETTLE when exactly one dgt bit is low.
  - SETTLE: settle counter increments while dgt and sseg hold their values; any change reloads counter to 0 (re-entering IDLE if dgt goes all-high). At count SETTLE-1, sample, go to HOLD.
  - HOLD: wait for dgt to change; then go to SETTLE or IDLE.
- Multi-hot dgt (two or more low bits): err pulse, frame discarded, state → IDLE until a legal dgt appears.
- Frame assembly: scan order is digit 0,1,2,3 ascending, cyclic. Sampling digit 0 starts a new frame (clears collected mask and frame error flag). Each next sample must be the previous index +1; otherwise the frame is discarded and collection waits for the next digit 0 (no err pulse). Illegal pattern: err pulse, frame error flag set.
- Sampling digit 3 with mask 0–2 complete and frame error flag clear → shadow copies to digits, frame_valid pulses. Otherwise digits holds.
- Re-sampling the same digit without an intervening change is impossible (HOLD); the same digit reselected after IDLE discards the frame.
- Timeout counter reloads to 0 on every sample; at TIMEOUT saturates and sets scan_lost. scan_lost clears on the next frame_valid. digits holds throughout.
- Widths: settle counter ceil(log2(SETTLE+1)) bits, timeout counter ceil(log2(TIMEOUT+1)) bits, both saturating, never wrap.

## Timing
- Reset values: digits=16'h0000, frame_valid=0, err=0, scan_lost=0, FSM=IDLE, mask=0.
- Reset asserted mid-frame discards the partial frame immediately; first frame_valid after release requires a full 0→3 scan.
- Input-to-sample latency: 2 (sync) + SETTLE clocks after the last change of dgt/sseg.
- frame_valid and digits update in the clock after the digit-3 sample; digits is stable for ≥1 full scan.
- err asserts the clock after the offending sample or multi-hot detection, exactly one cycle.
- Simultaneous timeout expiry and sample: sample wins, scan_lost not set.
- Simultaneous err (illegal digit 3) and frame completion: err pulses, no frame_valid.

## Test plan
- Clean scan of 12:34, 100 clocks per digit, order 0..3 repeated → digits=16'h1234, one frame_valid per 4-digit pass, err never set.
- Glitch of SETTLE-2 clocks on sseg during digit 2 of 23:59 → glitch ignored, digits=16'h2359.
- Digit 1 shows pattern 7F→49 (illegal) in one pass → one err pulse, no frame_valid that pass, digits holds previous value; next clean pass updates.
- Scan order 0,2,1,3 → no frame_valid, no err; restore ascending order → frame_valid on next digit 3.
- dgt held all-high for TIMEOUT clocks (set TIMEOUT=500) → scan_lost=1 at clock 500 after last sample; resume scan of 08:15 → scan_lost clears with frame_valid, digits=16'h0815.
- Assert reset_n low after digits 0–2 sampled, release, scan digit 3 only → no frame_valid, digits=16'h0000; dgt=4'b0011 → err pulse.
